// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, encodings and the byte-lane helper used by the slave memory.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Little-endian byte enables for an aligned access of 2^size bytes, up to 8 lanes.
  function automatic logic [7:0] size_to_be(input logic [2:0] size, input logic [2:0] lane_addr);
    logic [7:0] mask;
    case (size)
      HSIZE_BYTE: mask = 8'h01;
      HSIZE_HALF: mask = 8'h03;
      HSIZE_WORD: mask = 8'h0F;
      default:    mask = 8'hFF;
    endcase
    return mask << lane_addr;
  endfunction

endpackage

// File: rtl/ahb_if.sv
// AHB-Lite slave-side bus bundle shared by the memory, driver and monitor.
interface ahb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_core.sv
// DEPTH x DATA_W storage with a byte-enable write port and an asynchronous read port.
module ahb_sram_core #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Update only the enabled byte lanes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory with configurable wait states and a two-cycle ERROR response.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no data phase pending, ready high, OKAY
// WAIT    | OKAY data phase stalled, ready low, counting down wait states
// DATA    | OKAY data phase completes this cycle (write commits at edge)
// ERR1    | first ERROR cycle, ready low
// ERR2    | second ERROR cycle, ready high; may accept the next transfer
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic  clk,
  input logic  resetn,
  ahb_if.slave bus
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] MAX_SIZE = 3'(LANE_W);
  localparam logic [2:0] WS_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t             state_q;
  logic [2:0]         cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [LANE_W-1:0]  lane_q;
  logic [2:0]         size_q;
  logic               write_q;
  logic               hreadyout_q;
  hresp_t             hresp_q;

  logic               accept;
  logic               acc_err;
  logic               misaligned;
  logic               oversize;
  logic               out_of_range;
  logic [7:0]         lane8;
  state_t             acc_state_d;
  logic [7:0]         be_all;
  logic [DATA_W-1:0]  rdata;
  logic               mem_we;
  logic               unused_bits;

  assign accept       = bus.hsel & bus.hready & bus.htrans[1];
  assign lane8        = 8'(bus.haddr[LANE_W-1:0]);
  assign oversize     = bus.hsize > MAX_SIZE;
  assign out_of_range = (bus.haddr >> LANE_W) >= ADDR_W'(DEPTH);
  assign acc_err      = out_of_range | misaligned | oversize;

  // Alignment check on the low address bits for the requested size.
  always_comb begin
    misaligned = 1'b0;
    case (bus.hsize)
      HSIZE_BYTE:  misaligned = 1'b0;
      HSIZE_HALF:  misaligned = lane8[0];
      HSIZE_WORD:  misaligned = |lane8[1:0];
      HSIZE_DWORD: misaligned = |lane8[2:0];
      default:     misaligned = 1'b1;
    endcase
  end

  // Where an accepted address phase sends the FSM.
  always_comb begin
    acc_state_d = ST_DATA;
    if (acc_err) begin
      acc_state_d = ST_ERR1;
    end else if (WAIT_STATES > 0) begin
      acc_state_d = ST_WAIT;
    end
  end

  // Transfer sequencing with registered hreadyout/hresp.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      idx_q       <= '0;
      lane_q      <= '0;
      size_q      <= 3'd0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q     <= ST_DATA;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          if (accept) begin
            state_q     <= acc_state_d;
            cnt_q       <= WS_LOAD;
            idx_q       <= bus.haddr[LANE_W +: IDX_W];
            lane_q      <= bus.haddr[LANE_W-1:0];
            size_q      <= bus.hsize;
            write_q     <= bus.hwrite;
            hreadyout_q <= (acc_state_d == ST_DATA);
            hresp_q     <= acc_err ? HRESP_ERROR : HRESP_OKAY;
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign be_all = size_to_be(size_q, 3'(lane_q));
  assign mem_we = (state_q == ST_DATA) && write_q;

  ahb_sram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_core (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (be_all[NB-1:0]),
    .waddr_i (idx_q),
    .wdata_i (bus.hwdata),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = ((state_q == ST_DATA) && !write_q) ? rdata : '0;

  // Address bits above the array, burst/prot and unused lane enables carry no function here.
  assign unused_bits = ^{bus.haddr, bus.htrans[0], bus.hburst, bus.hprot, be_all};

endmodule
